// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the execute sequencer: ALU op codes,
// instruction field positions and FSM state encodings.
package exec_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_NOT = 3'd5;
  localparam logic [2:0] ALU_SHL = 3'd6;
  localparam logic [2:0] ALU_SHR = 3'd7;

  localparam int HALT_BIT = 11;
  localparam int OP_MSB   = 10;
  localparam int OP_LSB   = 8;
  localparam int INSTR_W  = 12;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/exec_sequencer_if.sv
// ROM fetch bus plus ALU/accumulator control bus between the sequencer
// (master) and the program ROM / execute datapath (slave).
interface exec_sequencer_if #(parameter int ADDR_W = 4) ();
  logic [ADDR_W-1:0] instr_addr;
  logic [11:0]       instr_data;
  logic [7:0]        acc;
  logic [7:0]        alu_op1;
  logic [7:0]        alu_op2;
  logic [2:0]        alu_operation;
  logic              acc_load;

  modport master (
    output instr_addr, alu_op1, alu_op2, alu_operation, acc_load,
    input  instr_data, acc
  );

  modport slave (
    input  instr_addr, alu_op1, alu_op2, alu_operation, acc_load,
    output instr_data, acc
  );
endinterface

// File: rtl/exec_sequencer.sv
// Control FSM that fetches, decodes and executes ALU instructions from a
// synchronous program ROM, one instruction every three cycles.
module exec_sequencer
  import exec_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  exec_sequencer_if.master  bus,
  output logic              busy,
  output logic              done,
  output logic [7:0]        instr_count
);

  localparam logic [2:0] S_IDLE   = 3'(ST_IDLE);
  localparam logic [2:0] S_FETCH  = 3'(ST_FETCH);
  localparam logic [2:0] S_DECODE = 3'(ST_DECODE);
  localparam logic [2:0] S_EXEC   = 3'(ST_EXEC);
  localparam logic [2:0] S_DONE   = 3'(ST_DONE);

  logic [2:0]        state;
  logic [ADDR_W-1:0] pc;
  // Halt flag is acted on in DECODE, so only op + immediate are held.
  logic [OP_MSB:0]   ir;
  logic [7:0]        cnt;

  // FSM plus PC / IR / instruction counter; PC stops at the last address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pc    <= '0;
            ir    <= '0;
            cnt   <= '0;
            state <= S_FETCH;
          end
        end
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          ir    <= bus.instr_data[OP_MSB:0];
          state <= bus.instr_data[HALT_BIT] ? S_DONE : S_EXEC;
        end
        S_EXEC: begin
          if (cnt != 8'hFF) cnt <= cnt + 8'd1;
          if (pc == '1) begin
            state <= S_DONE;
          end else begin
            pc    <= pc + 1'b1;
            state <= S_FETCH;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.instr_addr    = pc;
  assign bus.alu_op1       = bus.acc;
  assign bus.alu_op2       = ir[7:0];
  assign bus.alu_operation = ir[OP_MSB:OP_LSB];
  assign bus.acc_load      = (state == S_EXEC);
  assign busy              = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
  assign done              = (state == S_DONE);
  assign instr_count       = cnt;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench: ROM model, ALU and load-gated accumulator around the
// sequencer, with hand-computed expectations for each program.
module tb_exec_sequencer;
  import exec_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy, done;
  logic [7:0] instr_count;

  exec_sequencer_if #(.ADDR_W(4)) bus ();

  exec_sequencer #(.ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .busy(busy), .done(done), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  localparam logic [11:0] HALT = 12'h800;

  logic [11:0] rom [16];
  logic [7:0]  acc_q, alu_res, acc_set_val;
  logic        acc_set;

  always_ff @(posedge clk) bus.instr_data <= rom[bus.instr_addr];

  always_comb begin
    alu_res = 8'h00;
    case (bus.alu_operation)
      ALU_ADD: alu_res = bus.alu_op1 + bus.alu_op2;
      ALU_SUB: alu_res = bus.alu_op1 - bus.alu_op2;
      ALU_AND: alu_res = bus.alu_op1 & bus.alu_op2;
      ALU_OR:  alu_res = bus.alu_op1 | bus.alu_op2;
      ALU_XOR: alu_res = bus.alu_op1 ^ bus.alu_op2;
      ALU_NOT: alu_res = ~bus.alu_op1;
      ALU_SHL: alu_res = bus.alu_op1 << bus.alu_op2[2:0];
      ALU_SHR: alu_res = bus.alu_op1 >> bus.alu_op2[2:0];
      default: alu_res = 8'h00;
    endcase
  end

  always_ff @(posedge clk)
    if (acc_set) acc_q <= acc_set_val;
    else if (bus.acc_load) acc_q <= alu_res;

  assign bus.acc = acc_q;

  int          checks = 0;
  int          failures = 0;
  int          done_c;
  int          nops;
  int          idle_busy;
  logic [63:0] lmask;
  logic [2:0]  ops [16];
  logic [3:0]  end_addr;

  function automatic logic [11:0] ins(input logic [2:0] op, input logic [7:0] imm);
    return {1'b0, op, imm};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rom_fill_halt();
    for (int i = 0; i < 16; i++) rom[i] = HALT;
  endtask

  task automatic set_acc(input logic [7:0] v);
    @(negedge clk);
    acc_set = 1'b1; acc_set_val = v;
    @(negedge clk);
    acc_set = 1'b0;
  endtask

  // Start at edge 0, then observe cycles 1..maxc at the falling edge.
  task automatic run(input int restart_c, input int maxc);
    done_c = -1; lmask = '0; nops = 0; idle_busy = -1; end_addr = 'x;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk);
      start = (c == restart_c);
      if (bus.acc_load === 1'b1) begin
        lmask[c] = 1'b1;
        if (nops < 16) ops[nops] = bus.alu_operation;
        nops++;
      end
      if (done === 1'b1 && done_c < 0) begin
        done_c   = c;
        end_addr = bus.instr_addr;
      end else if (done_c >= 0) begin
        idle_busy = int'(busy);
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; acc_set = 1'b0; acc_set_val = 8'h00;
    rom_fill_halt();
    repeat (2) @(negedge clk);
    chk("rst_instr_addr", 64'(bus.instr_addr), 0);
    chk("rst_alu_op2",    64'(bus.alu_op2), 0);
    chk("rst_alu_oper",   64'(bus.alu_operation), 0);
    chk("rst_acc_load",   64'(bus.acc_load), 0);
    chk("rst_busy",       64'(busy), 0);
    chk("rst_done",       64'(done), 0);
    chk("rst_count",      64'(instr_count), 0);
    reset = 1'b0;

    // Program 1: ADD 5, ADD 3, HALT
    rom_fill_halt();
    rom[0] = ins(ALU_ADD, 8'd5); rom[1] = ins(ALU_ADD, 8'd3);
    set_acc(8'h5A);
    chk("alu_op1_follows", 64'(bus.alu_op1), 64'h5A);
    set_acc(8'h00);
    run(0, 40);
    chk("p1_done_cycle", 64'(done_c), 9);
    chk("p1_acc",        64'(acc_q), 8);
    chk("p1_count",      64'(instr_count), 2);
    chk("p1_load_mask",  lmask, 64'h48);
    chk("p1_idle_busy",  64'(idle_busy), 0);

    // Program 2: ADD F0, SUB 10, AND 3C, HALT
    rom_fill_halt();
    rom[0] = ins(ALU_ADD, 8'hF0); rom[1] = ins(ALU_SUB, 8'h10);
    rom[2] = ins(ALU_AND, 8'h3C);
    set_acc(8'h00);
    run(0, 40);
    chk("p2_acc",        64'(acc_q), 64'h20);
    chk("p2_done_cycle", 64'(done_c), 12);
    chk("p2_nops",       64'(nops), 3);
    chk("p2_op0",        64'(ops[0]), 0);
    chk("p2_op1",        64'(ops[1]), 1);
    chk("p2_op2",        64'(ops[2]), 2);
    chk("p2_count",      64'(instr_count), 3);

    // Halt at address 0
    rom_fill_halt();
    set_acc(8'h77);
    run(0, 20);
    chk("h0_done_cycle", 64'(done_c), 3);
    chk("h0_load_mask",  lmask, 0);
    chk("h0_count",      64'(instr_count), 0);
    chk("h0_acc",        64'(acc_q), 64'h77);

    // Full ROM of ADD 1, no halt
    for (int i = 0; i < 16; i++) rom[i] = ins(ALU_ADD, 8'd1);
    set_acc(8'h00);
    run(0, 60);
    chk("full_done_cycle", 64'(done_c), 49);
    chk("full_acc",        64'(acc_q), 16);
    chk("full_end_addr",   64'(end_addr), 15);
    chk("full_count",      64'(instr_count), 16);
    chk("full_idle_busy",  64'(idle_busy), 0);

    // Program 1 with a stray start in cycle 4
    rom_fill_halt();
    rom[0] = ins(ALU_ADD, 8'd5); rom[1] = ins(ALU_ADD, 8'd3);
    set_acc(8'h00);
    run(4, 40);
    chk("rs_done_cycle", 64'(done_c), 9);
    chk("rs_acc",        64'(acc_q), 8);
    chk("rs_count",      64'(instr_count), 2);
    chk("rs_load_mask",  lmask, 64'h48);

    // Reset in cycle 5 of program 1
    set_acc(8'h00);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("mid_count_pre", 64'(instr_count), 1);
    reset = 1'b1;
    #1;
    chk("mid_busy",  64'(busy), 0);
    chk("mid_addr",  64'(bus.instr_addr), 0);
    chk("mid_count", 64'(instr_count), 0);
    @(negedge clk);
    chk("mid_busy_edge", 64'(busy), 0);
    chk("mid_done_edge", 64'(done), 0);
    chk("mid_load_edge", 64'(bus.acc_load), 0);
    reset = 1'b0;
    set_acc(8'h00);
    run(0, 40);
    chk("post_done_cycle", 64'(done_c), 9);
    chk("post_acc",        64'(acc_q), 8);
    chk("post_count",      64'(instr_count), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
